// File: rtl/micro_apb_master.sv
// -----------------------------------------------------------------------------
// micro_apb_master
//
// APB3 initiator driven by a simple command/response handshake. One transfer is
// outstanding at a time. A debug or boot path (for example a UART command
// parser) uses it to read and write peripheral registers.
//
// Optional feature macro: MICRO_APB_MASTER_TIMEOUT_EN
//   Defined   : ACCESS is force-terminated with an error response after TIMEOUT
//               cycles without apb_pready.
//   Undefined : ACCESS waits indefinitely for apb_pready.
//
// Parameters
//   ADDR_W   APB address width in bits
//   TIMEOUT  ACCESS-phase cycle limit (1..65535), only used with the macro
//
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   cmd_valid/cmd_ready          command handshake
//   cmd_write/addr/wdata         command payload
//   rsp_valid                    one-cycle response strobe (no backpressure)
//   rsp_rdata/rsp_error          response payload, held until the next response
//   apb_*                        APB3 master interface
// -----------------------------------------------------------------------------
module micro_apb_master #(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [31:0]       cmd_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_error,
    output logic              apb_psel,
    output logic              apb_penable,
    output logic              apb_pwrite,
    output logic [ADDR_W-1:0] apb_paddr,
    output logic [31:0]       apb_pwdata,
    input  logic [31:0]       apb_prdata,
    input  logic              apb_pready,
    input  logic              apb_pslverr
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t r_state;

    // Elaboration-time guard on the timeout range
    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_timeout_range
        $error("micro_apb_master: TIMEOUT out of range 1..65535");
    end

`ifdef MICRO_APB_MASTER_TIMEOUT_EN
    // The counter holds the number of pready=0 ACCESS cycles already completed,
    // so the limit is reached on the edge ending the TIMEOUT-th waiting cycle.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
    logic [15:0] r_to_cnt;
`endif

    // Transfer FSM; every output is a register updated here
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            cmd_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= 32'h0000_0000;
            rsp_error   <= 1'b0;
            apb_psel    <= 1'b0;
            apb_penable <= 1'b0;
            apb_pwrite  <= 1'b0;
            apb_paddr   <= '0;
            apb_pwdata  <= 32'h0000_0000;
`ifdef MICRO_APB_MASTER_TIMEOUT_EN
            r_to_cnt    <= 16'd0;
`endif
        end else begin
            // Response strobe is a single-cycle pulse
            rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        apb_pwrite <= cmd_write;
                        apb_paddr  <= cmd_addr;
                        apb_pwdata <= cmd_wdata;
                        apb_psel   <= 1'b1;
                        cmd_ready  <= 1'b0;
                        r_state    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    apb_penable <= 1'b1;
                    r_state     <= ST_ACCESS;
`ifdef MICRO_APB_MASTER_TIMEOUT_EN
                    r_to_cnt    <= 16'd0;
`endif
                end
                ST_ACCESS: begin
                    if (apb_pready) begin
                        // Normal completion wins over a coincident timeout
                        apb_psel    <= 1'b0;
                        apb_penable <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= apb_pwrite ? 32'h0000_0000 : apb_prdata;
                        rsp_error   <= apb_pslverr;
                        cmd_ready   <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
`ifdef MICRO_APB_MASTER_TIMEOUT_EN
                    else if (r_to_cnt == TO_LAST) begin
                        apb_psel    <= 1'b0;
                        apb_penable <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= 32'h0000_0000;
                        rsp_error   <= 1'b1;
                        cmd_ready   <= 1'b1;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 16'd1;
                    end
`endif
                end
                default: begin
                    // Unreachable encoding: drop the bus and return to idle
                    apb_psel    <= 1'b0;
                    apb_penable <= 1'b0;
                    cmd_ready   <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_micro_apb_master.sv
// -----------------------------------------------------------------------------
// tb_micro_apb_master
//
// Directed self-checking bench for micro_apb_master. Inputs are driven 1 time
// unit after the rising edge and outputs are checked at the same point, so each
// check observes the registered state produced by the preceding edge.
// -----------------------------------------------------------------------------
module tb_micro_apb_master;

    localparam int ADDR_W = 16;

    logic              clk       = 1'b0;
    logic              reset_n   = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_write = 1'b0;
    logic [ADDR_W-1:0] cmd_addr  = 16'h0000;
    logic [31:0]       cmd_wdata = 32'h0000_0000;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_error;
    logic              apb_psel;
    logic              apb_penable;
    logic              apb_pwrite;
    logic [ADDR_W-1:0] apb_paddr;
    logic [31:0]       apb_pwdata;
    logic [31:0]       apb_prdata  = 32'h0000_0000;
    logic              apb_pready  = 1'b0;
    logic              apb_pslverr = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    micro_apb_master #(.ADDR_W(ADDR_W), .TIMEOUT(4)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_error   (rsp_error),
        .apb_psel    (apb_psel),
        .apb_penable (apb_penable),
        .apb_pwrite  (apb_pwrite),
        .apb_paddr   (apb_paddr),
        .apb_pwdata  (apb_pwdata),
        .apb_prdata  (apb_prdata),
        .apb_pready  (apb_pready),
        .apb_pslverr (apb_pslverr)
    );

    // Free-running clock, period 10
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int bad_cycles;

    initial begin
        // ---------------- reset state ----------------
        #12;
        chk_eq("rst_cmd_ready", cmd_ready,   1);
        chk_eq("rst_psel",      apb_psel,    0);
        chk_eq("rst_penable",   apb_penable, 0);
        chk_eq("rst_rsp_valid", rsp_valid,   0);
        chk_eq("rst_paddr",     apb_paddr,   0);
        chk_eq("rst_pwdata",    apb_pwdata,  0);
        chk_eq("rst_rdata",     rsp_rdata,   0);
        chk_eq("rst_error",     rsp_error,   0);
        reset_n = 1'b1;
        step();

        // ---------------- zero-wait write ----------------
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0004; cmd_wdata = 32'h0000_0123;
        apb_pready = 1'b1; apb_prdata = 32'hDEAD_BEEF;
        step();                                   // accept edge
        cmd_valid = 1'b0;
        chk_eq("wr_setup_psel",    apb_psel,    1);
        chk_eq("wr_setup_penable", apb_penable, 0);
        chk_eq("wr_setup_ready",   cmd_ready,   0);
        chk_eq("wr_pwrite",        apb_pwrite,  1);
        chk_eq("wr_paddr",         apb_paddr,   32'h0004);
        chk_eq("wr_pwdata",        apb_pwdata,  32'h0000_0123);
        step();
        chk_eq("wr_access_psel",    apb_psel,    1);
        chk_eq("wr_access_penable", apb_penable, 1);
        chk_eq("wr_access_rspv",    rsp_valid,   0);
        step();
        chk_eq("wr_rsp_valid", rsp_valid,   1);
        chk_eq("wr_rsp_error", rsp_error,   0);
        chk_eq("wr_rsp_rdata", rsp_rdata,   0);
        chk_eq("wr_done_psel", apb_psel,    0);
        chk_eq("wr_done_pen",  apb_penable, 0);
        chk_eq("wr_done_rdy",  cmd_ready,   1);
        step();
        chk_eq("wr_rsp_pulse", rsp_valid,   0);
        chk_eq("wr_idle_psel", apb_psel,    0);
        chk_eq("wr_pwdata_kept", apb_pwdata, 32'h0000_0123);

        // ---------------- read with 3 wait states ----------------
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0000; cmd_wdata = 32'h5555_5555;
        apb_pready = 1'b0; apb_pslverr = 1'b1; apb_prdata = 32'h1234_5678;
        step();                                   // accept
        cmd_valid = 1'b0; cmd_addr = 16'hBEEF;
        chk_eq("rd_setup_pwrite", apb_pwrite, 0);
        step();                                   // ACCESS cycle 1
        for (int i = 0; i < 3; i++) begin
            chk_eq("rd_wait_psel",  apb_psel,    1);
            chk_eq("rd_wait_pen",   apb_penable, 1);
            chk_eq("rd_wait_paddr", apb_paddr,   32'h0000);
            chk_eq("rd_wait_rspv",  rsp_valid,   0);
            step();
        end
        apb_pready = 1'b1; apb_pslverr = 1'b0; apb_prdata = 32'hA5A5_005A;
        chk_eq("rd_last_paddr", apb_paddr, 32'h0000);
        step();
        apb_pready = 1'b0; apb_prdata = 32'h0000_0000;
        chk_eq("rd_rsp_valid", rsp_valid, 1);
        chk_eq("rd_rsp_rdata", rsp_rdata, 32'hA5A5_005A);
        chk_eq("rd_rsp_error", rsp_error, 0);
        step();
        chk_eq("rd_rsp_pulse", rsp_valid, 0);
        chk_eq("rd_rdata_hold", rsp_rdata, 32'hA5A5_005A);

        // ---------------- slave error then clean read ----------------
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0010;
        apb_pready = 1'b1; apb_pslverr = 1'b1; apb_prdata = 32'h1111_1111;
        step(); cmd_valid = 1'b0;
        step(); step();
        chk_eq("err_rsp_valid", rsp_valid, 1);
        chk_eq("err_rsp_error", rsp_error, 1);
        chk_eq("err_rsp_rdata", rsp_rdata, 32'h1111_1111);
        apb_pslverr = 1'b0;
        step();
        chk_eq("err_hold", rsp_error, 1);
        cmd_valid = 1'b1; cmd_addr = 16'h0014; apb_prdata = 32'h2222_0000;
        step(); cmd_valid = 1'b0;
        step(); step();
        chk_eq("ok_rsp_valid", rsp_valid, 1);
        chk_eq("ok_rsp_error", rsp_error, 0);
        chk_eq("ok_rsp_rdata", rsp_rdata, 32'h2222_0000);
        step();

        // ---------------- back-to-back reads ----------------
        cmd_valid = 1'b1; cmd_write = 1'b0; apb_pready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cmd_addr   = 16'(16'h0100 + 4 * k);
            apb_prdata = 32'hB0B0_0000 + 32'(k);
            step();                               // accept at cycle 3k
            chk_eq("b2b_setup_psel", apb_psel,    1);
            chk_eq("b2b_setup_pen",  apb_penable, 0);
            chk_eq("b2b_paddr",      apb_paddr,   32'(16'h0100 + 4 * k));
            cmd_addr = 16'hFFFF;                  // must be ignored outside IDLE
            step();
            chk_eq("b2b_access_pen",   apb_penable, 1);
            chk_eq("b2b_access_paddr", apb_paddr,   32'(16'h0100 + 4 * k));
            step();
            chk_eq("b2b_rsp_valid", rsp_valid, 1);
            chk_eq("b2b_cmd_ready", cmd_ready, 1);
            chk_eq("b2b_rsp_rdata", rsp_rdata, 32'hB0B0_0000 + 32'(k));
        end
        cmd_valid = 1'b0;
        step();
        chk_eq("b2b_end_rspv", rsp_valid, 0);
        chk_eq("b2b_end_psel", apb_psel,  0);

`ifdef MICRO_APB_MASTER_TIMEOUT_EN
        // ---------------- timeout after 4 ACCESS cycles ----------------
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0200;
        apb_pready = 1'b0; apb_prdata = 32'hCAFE_F00D;
        step(); cmd_valid = 1'b0;
        step();                                   // ACCESS cycle 1
        for (int i = 0; i < 4; i++) begin
            chk_eq("to_wait_psel", apb_psel,  1);
            chk_eq("to_wait_rspv", rsp_valid, 0);
            step();
        end
        chk_eq("to_rsp_valid", rsp_valid,   1);
        chk_eq("to_rsp_error", rsp_error,   1);
        chk_eq("to_rsp_rdata", rsp_rdata,   0);
        chk_eq("to_psel",      apb_psel,    0);
        chk_eq("to_penable",   apb_penable, 0);
        chk_eq("to_cmd_ready", cmd_ready,   1);
        step();
`endif

        // ---------------- reset mid-ACCESS ----------------
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0300; apb_pready = 1'b0;
        step(); cmd_valid = 1'b0;
        step();                                   // in ACCESS
        chk_eq("mid_psel_before", apb_psel, 1);
        #2 reset_n = 1'b0;
        #1;
        chk_eq("mid_rst_psel",    apb_psel,    0);
        chk_eq("mid_rst_penable", apb_penable, 0);
        chk_eq("mid_rst_rspv",    rsp_valid,   0);
        chk_eq("mid_rst_ready",   cmd_ready,   1);
        chk_eq("mid_rst_paddr",   apb_paddr,   0);
        #2 reset_n = 1'b1;
        apb_pready = 1'b1;
        step();
        chk_eq("mid_after_rspv", rsp_valid, 0);
        chk_eq("mid_after_psel", apb_psel,  0);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0008; cmd_wdata = 32'h0000_00AB;
        step(); cmd_valid = 1'b0;
        chk_eq("rec_pwdata", apb_pwdata, 32'h0000_00AB);
        step(); step();
        chk_eq("rec_rsp_valid", rsp_valid, 1);
        chk_eq("rec_rsp_error", rsp_error, 0);
        step();

`ifndef MICRO_APB_MASTER_TIMEOUT_EN
        // ---------------- no timeout: bus held for 1000 cycles ----------------
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0400; apb_pready = 1'b0;
        step(); cmd_valid = 1'b0;
        step();
        bad_cycles = 0;
        for (int i = 0; i < 1000; i++) begin
            if (apb_psel !== 1'b1 || rsp_valid !== 1'b0) bad_cycles++;
            step();
        end
        chk_eq("no_timeout_hold", bad_cycles, 0);
        reset_n = 1'b0;
        #2 reset_n = 1'b1;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
